ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch.sv | 158 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-limited instruction prefetcher feeding an in-order {pc, inst} queue.
// Latency: fetch issue -> out_valid after 2 cycles; redirect -> target on out after 3 cycles.
// Backpressure: out_ready=0 holds the head; fetch stops when queued + in-flight reaches DEPTH.
// Optional: define IFU_PREFETCH_PERF_EN to build the perf_fetch_cnt / perf_flush_cnt counters.

module ifu_prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push_vld && (count != FULL_C);
  assign pop_ok   = pop_vld && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only; validity comes from count, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push_ok && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_snpc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic [CW-1:0] occ;
  logic [CW:0]   credit_used;
  logic [63:0]   head_dat;
  logic          push_vld;
  logic          pop_vld;
  logic [1:0]    redirect_pc_unused;

  assign redirect_pc_unused = redirect_pc[1:0];

  // In-flight fetches hold a queue slot so a response always has room to land.
  assign credit_used = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign irom_req    = reset && !redirect_valid && (credit_used < DEPTH_C);
  assign irom_addr   = fetch_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= irom_req;
      if (irom_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_pc   <= fetch_pc;
      end
    end
  end

  // A response landing in a redirect cycle belongs to the old path and is dropped.
  assign push_vld = inflight && !redirect_valid;
  assign pop_vld  = out_valid && out_ready;

  ifu_prefetch_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .clr      (redirect_valid),
    .push_vld (push_vld),
    .push_dat ({tag_pc, irom_data}),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (occ)
  );

  assign out_valid = (occ != '0);
  assign out_pc    = head_dat[63:32];
  assign out_inst  = head_dat[31:0];
  assign out_snpc  = out_pc + 32'd4;

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push_vld)       fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus a randomized run against a queue-level model.
module tb_ifu_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic [31:0] irom_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_snpc;
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  ifu_prefetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .irom_req       (irom_req),
    .irom_addr      (irom_addr),
    .irom_data      (irom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_snpc       (out_snpc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory: answers each request in the following cycle.
  logic        pend_req = 1'b0;
  logic [31:0] pend_addr = '0;
  always @(negedge clock) begin
    pend_req  = irom_req;
    pend_addr = irom_addr;
  end
  always @(posedge clock) begin
    #1;
    irom_data = pend_req ? memf(pend_addr) : 32'hDEAD_BEEF;
  end

  // Queue-level reference: outstanding = queued + in-flight fetches.
  int          m_out;
  bit          m_infl;
  logic [31:0] m_fetch, m_head;
  int unsigned m_push, m_flush;

  task automatic model_reset();
    m_out = 0; m_infl = 0; m_fetch = RPC; m_head = RPC; m_push = 0; m_flush = 0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit req, pop;
    req = !rv && (m_out < DEPTH);
    pop = ((m_out - int'(m_infl)) != 0) && rdy;
    if (rv) begin
      m_out = 0; m_infl = 0; m_fetch = {rpc[31:2], 2'b00}; m_head = m_fetch; m_flush++;
    end else begin
      if (m_infl) m_push++;
      m_out = m_out + int'(req) - int'(pop);
      m_infl = req;
      if (req) m_fetch = m_fetch + 32'd4;
      if (pop) m_head = m_head + 32'd4;
    end
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 0; out_ready = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; out_ready = 1; redirect_valid = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if ({irom_req, out_valid, irom_addr} !== {2'b00, RPC}) begin
      n_fail++; $display("FAIL reset_outputs got %h exp %h", {irom_req, out_valid, irom_addr}, {2'b00, RPC});
    end
    n_chk++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_perf got %h exp 0", {perf_fetch_cnt, perf_flush_cnt});
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    apply_reset();
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_chk++;
      if ({irom_req, irom_addr} !== {1'b1, 32'(4*c)}) begin
        n_fail++; $display("FAIL stream_fetch c%0d got %h exp %h", c, {irom_req, irom_addr}, {1'b1, 32'(4*c)});
      end
      e = 32'(4*(c-2));
      n_chk++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_early_valid c%0d got %b exp 0", c, out_valid);
        end
      end else if ({out_valid, out_pc, out_inst, out_snpc} !== {1'b1, e, memf(e), e + 32'd4}) begin
        n_fail++; $display("FAIL stream_out c%0d got %h exp %h", c, {out_valid, out_pc, out_inst, out_snpc}, {1'b1, e, memf(e), e + 32'd4});
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_chk++;
      if (c < 4) begin
        if ({irom_req, irom_addr} !== {1'b1, 32'(4*c)}) begin
          n_fail++; $display("FAIL bp_fetch c%0d got %h exp %h", c, {irom_req, irom_addr}, {1'b1, 32'(4*c)});
        end
      end else if (irom_req !== 1'b0) begin
        n_fail++; $display("FAIL bp_credit c%0d got %b exp 0", c, irom_req);
      end
      if (c >= 2) begin
        n_chk++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
          n_fail++; $display("FAIL bp_hold c%0d got %h exp %h", c, {out_valid, out_pc}, {1'b1, 32'h0});
        end
      end
    end
    @(posedge clock); #1 out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_chk++;
      if ({out_valid, out_pc} !== {1'b1, 32'(4*k)}) begin
        n_fail++; $display("FAIL bp_drain k%0d got %h exp %h", k, {out_valid, out_pc}, {1'b1, 32'(4*k)});
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    apply_reset();
    repeat (8) @(posedge clock);
    #1 redirect_valid = 1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    n_chk++;
    if ({irom_req, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL redir_cycle got %b exp 01", {irom_req, out_valid});
    end
    @(posedge clock); #1 redirect_valid = 0; out_ready = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      e = 32'h100 + 32'(4*(k-1));
      n_chk++;
      if ({irom_req, irom_addr} !== {1'b1, e}) begin
        n_fail++; $display("FAIL redir_fetch k%0d got %h exp %h", k, {irom_req, irom_addr}, {1'b1, e});
      end
      e = 32'h100 + 32'(4*(k-3));
      n_chk++;
      if (k < 3) begin
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_stale k%0d got %b %h exp 0", k, out_valid, out_pc);
        end
      end else if ({out_valid, out_pc, out_inst} !== {1'b1, e, memf(e)}) begin
        n_fail++; $display("FAIL redir_out k%0d got %h exp %h", k, {out_valid, out_pc, out_inst}, {1'b1, e, memf(e)});
      end
    end
    // Back-to-back redirects: only the second target may reach the output.
    @(posedge clock); #1 redirect_valid = 1; redirect_pc = 32'h0000_0200;
    @(negedge clock);
    n_chk++;
    if (irom_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got %b exp 0", irom_req);
    end
    @(posedge clock); #1 redirect_pc = 32'h0000_0303;
    @(negedge clock);
    n_chk++;
    if ({irom_req, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second got %b exp 00", {irom_req, out_valid});
    end
    @(posedge clock); #1 redirect_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      e = 32'h300 + 32'(4*(k-3));
      n_chk++;
      if (k == 1 && {irom_req, irom_addr, out_valid} !== {1'b1, 32'h300, 1'b0}) begin
        n_fail++; $display("FAIL b2b_fetch got %h exp %h", {irom_req, irom_addr, out_valid}, {1'b1, 32'h300, 1'b0});
      end else if (k == 2 && out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_stale got %b %h exp 0", out_valid, out_pc);
      end else if (k >= 3 && {out_valid, out_pc} !== {1'b1, e}) begin
        n_fail++; $display("FAIL b2b_out k%0d got %h exp %h", k, {out_valid, out_pc}, {1'b1, e});
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e, f;
    out_ready = 1;
    @(posedge clock); #1 redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    @(posedge clock); #1 redirect_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      f = 32'hFFFF_FFF8 + 32'(4*(k-1));
      e = 32'hFFFF_FFF8 + 32'(4*(k-3));
      n_chk++;
      if ({irom_req, irom_addr} !== {1'b1, f}) begin
        n_fail++; $display("FAIL wrap_fetch k%0d got %h exp %h", k, {irom_req, irom_addr}, {1'b1, f});
      end
      if (k >= 3) begin
        n_chk++;
        if ({out_valid, out_pc, out_inst, out_snpc} !== {1'b1, e, memf(e), e + 32'd4}) begin
          n_fail++; $display("FAIL wrap_out k%0d got %h exp %h", k, {out_valid, out_pc, out_inst, out_snpc}, {1'b1, e, memf(e), e + 32'd4});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (5) @(negedge clock);
    n_chk++;
    if ({irom_req, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL rmid_pre got %b exp 01", {irom_req, out_valid});
    end
    #1 reset = 0;
    #1;
    n_chk++;
    if ({irom_req, out_valid, irom_addr} !== {2'b00, RPC}) begin
      n_fail++; $display("FAIL rmid_async got %h exp %h", {irom_req, out_valid, irom_addr}, {2'b00, RPC});
    end
    repeat (2) @(posedge clock);
    #1 reset = 1; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_chk++;
      if ({irom_req, irom_addr, out_valid} !== {1'b1, RPC + 32'(4*c), c >= 2}) begin
        n_fail++; $display("FAIL rmid_restart c%0d got %h exp %h", c, {irom_req, irom_addr, out_valid}, {1'b1, RPC + 32'(4*c), c >= 2});
      end
      if (c >= 2) begin
        n_chk++;
        if (out_pc !== RPC + 32'(4*(c-2))) begin
          n_fail++; $display("FAIL rmid_out c%0d got %h exp %h", c, out_pc, RPC + 32'(4*(c-2)));
        end
      end
    end
  endtask

  task automatic test_perf();
    logic [63:0] e;
    apply_reset();
    out_ready = 1;
    repeat (11) @(posedge clock);
    #1 redirect_valid = 1; redirect_pc = 32'h40;
    @(posedge clock); #1 redirect_valid = 0;
    @(posedge clock); #1 redirect_valid = 1;
    @(posedge clock); #1 redirect_valid = 0;
    @(negedge clock);
`ifdef IFU_PREFETCH_PERF_EN
    e = {32'd10, 32'd2};
`else
    e = 64'h0;
`endif
    n_chk++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== e) begin
      n_fail++; $display("FAIL perf_counts got %h exp %h", {perf_fetch_cnt, perf_flush_cnt}, e);
    end
  endtask

  task automatic test_random();
    bit          e_req, e_vld;
    logic [63:0] e_perf;
    apply_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      e_req = !redirect_valid && (m_out < DEPTH);
      e_vld = (m_out - int'(m_infl)) != 0;
      n_chk++;
      if (irom_req !== e_req || (e_req && irom_addr !== m_fetch)) begin
        n_fail++; $display("FAIL rnd_fetch i%0d got %b %h exp %b %h", i, irom_req, irom_addr, e_req, m_fetch);
      end
      n_chk++;
      if (out_valid !== e_vld || (e_vld && {out_pc, out_inst, out_snpc} !== {m_head, memf(m_head), m_head + 32'd4})) begin
        n_fail++; $display("FAIL rnd_out i%0d got %b %h exp %b %h", i, out_valid, out_pc, e_vld, m_head);
      end
`ifdef IFU_PREFETCH_PERF_EN
      e_perf = {m_push, m_flush};
`else
      e_perf = 64'h0;
`endif
      n_chk++;
      if ({perf_fetch_cnt, perf_flush_cnt} !== e_perf) begin
        n_fail++; $display("FAIL rnd_perf i%0d got %h exp %h", i, {perf_fetch_cnt, perf_flush_cnt}, e_perf);
      end
      model_step(redirect_valid, redirect_pc, out_ready);
      @(posedge clock); #1;
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                          redirect_pc = $urandom();
    end
    redirect_valid = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_perf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
